// File: rtl/gpio_in_edge_if.sv
// gpio_in_edge_if: Avalon-MM slave bus bundle for the gpio_in_edge input port.
// The master side drives address/strobes/data; the slave returns registered
// read data and the level interrupt.
interface gpio_in_edge_if;
  logic [1:0]  address;
  logic        write_n;
  logic        chipselect;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output write_n,
    output chipselect,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  write_n,
    input  chipselect,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/gpio_in_edge.sv
// gpio_in_edge: Avalon-MM general-purpose input port.
// Each input bit goes through a two-flop synchroniser and a debounce filter;
// accepted transitions of the selected polarity latch into a sticky,
// write-1-to-clear capture register that drives a maskable level interrupt.
// Register 0 returns the debounced input value, so a WIDTH=1 instance with no
// write traffic behaves like the plain input PIO it replaces.
module gpio_in_edge #(
  parameter int WIDTH           = 8,  // 1..32
  parameter int DEBOUNCE_CYCLES = 1,  // 1..65535, 1 = no filtering
  parameter int EDGE_TYPE       = 0   // 0 rising, 1 falling, 2 any
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_in_edge_if.slave    bus,
  input  logic [WIDTH-1:0] in_port
);

  // Counter wide enough to hold DEBOUNCE_CYCLES-1 (one spare bit for D=1).
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Synchroniser stages.
  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;

  // Debounced value and per-bit edge events, assembled from the per-bit slices.
  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] edge_event;

  // Software-visible registers.
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] irq_mask_next;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] cap_clear;

  // Bus outputs.
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             irq_reg;

  logic             wr_en;
  logic             unused_wdata;

  // Two-flop synchroniser for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= in_port;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_reg;
      logic             differs;
      logic             accept;
      logic             edge_hit;

      // A change is accepted once the synchronised input has disagreed with
      // the debounced value for DEBOUNCE_CYCLES consecutive cycles.
      assign differs = (s2_reg[gi] != stable_reg);
      assign accept  = differs && (cnt_reg == CNT_LAST);

      // Per-bit debounce: count disagreeing cycles, restart on any agreement.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (!differs) begin
          cnt_reg    <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          stable_reg <= s2_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg    <= cnt_reg + CNT_W'(1);
        end
      end

      // Polarity filter: the accepted new value tells us the edge direction.
      if (EDGE_TYPE == 0) begin : g_rise
        assign edge_hit = s2_reg[gi];
      end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_hit = ~s2_reg[gi];
      end else begin : g_any
        assign edge_hit = 1'b1;
      end

      assign edge_event[gi] = accept & edge_hit;
      assign stable_vec[gi] = stable_reg;
    end
  endgenerate

  assign wr_en = bus.chipselect && !bus.write_n;

  // Bits above WIDTH carry no meaning on writes.
  assign unused_wdata = ^bus.writedata;

  // Register write decode; a capture set always wins over a same-cycle clear.
  always_comb begin
    irq_mask_next = irq_mask_reg;
    cap_clear     = '0;
    if (wr_en && (bus.address == ADDR_MASK)) begin
      irq_mask_next = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      cap_clear = bus.writedata[WIDTH-1:0];
    end
    edgecap_next = (edgecap_reg & ~cap_clear) | edge_event;
  end

  // Read mux from current register state; unused upper bits stay zero.
  always_comb begin
    readdata_next = '0;
    case (bus.address)
      ADDR_DATA:    readdata_next[WIDTH-1:0] = stable_vec;
      ADDR_MASK:    readdata_next[WIDTH-1:0] = irq_mask_reg;
      ADDR_EDGECAP: readdata_next[WIDTH-1:0] = edgecap_reg;
      default:      readdata_next = '0;
    endcase
  end

  // Register state and outputs; irq is computed from next-state values so it
  // tracks mask writes and capture updates on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_reg <= '0;
      edgecap_reg  <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      irq_mask_reg <= irq_mask_next;
      edgecap_reg  <= edgecap_next;
      readdata_reg <= readdata_next;
      irq_reg      <= |(edgecap_next & irq_mask_next);
    end
  end

  assign bus.readdata = readdata_reg;
  assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_gpio_in_edge.sv
// tb_gpio_in_edge: three gpio_in_edge instances (rising, falling, any) share
// the same inputs and bus traffic. A reference model predicts readdata/irq per
// clock edge into a queue; a monitor pops and compares on the falling edge.
module tb_gpio_in_edge;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic [W-1:0] in_port    = '0;
  logic [1:0]   address    = '0;
  logic         write_n    = 1'b1;
  logic         chipselect = 1'b0;
  logic [31:0]  writedata  = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_in_edge_if bus_r ();
  gpio_in_edge_if bus_f ();
  gpio_in_edge_if bus_a ();

  assign bus_r.address = address;    assign bus_r.write_n = write_n;
  assign bus_r.chipselect = chipselect; assign bus_r.writedata = writedata;
  assign bus_f.address = address;    assign bus_f.write_n = write_n;
  assign bus_f.chipselect = chipselect; assign bus_f.writedata = writedata;
  assign bus_a.address = address;    assign bus_a.write_n = write_n;
  assign bus_a.chipselect = chipselect; assign bus_a.writedata = writedata;

  gpio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port));
  gpio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_port));
  gpio_in_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0][31:0] rd;
    logic [2:0]       irq;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] sync_q[$];   // raw samples still travelling through the synchroniser
  logic [W-1:0] seen_q[$];   // last D synchronised samples, oldest first
  logic [W-1:0] m_acc;       // accepted (debounced) value
  logic [W-1:0] m_mask;
  logic [2:0][W-1:0] m_cap;

  task automatic reset_model();
    sync_q.delete();
    seen_q.delete();
    sync_q.push_back('0);
    sync_q.push_back('0);
    for (int i = 0; i < D; i++) seen_q.push_back('0);
    m_acc  = '0;
    m_mask = '0;
    m_cap  = '0;
  endtask

  function automatic logic mode_hit(input int mode, input logic newv);
    return (mode == 2) || (mode == 0 && newv) || (mode == 1 && !newv);
  endfunction

  function automatic logic [31:0] read_reg(input logic [1:0] a, input int m);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0:    r[W-1:0] = m_acc;
      2'd2:    r[W-1:0] = m_mask;
      2'd3:    r[W-1:0] = m_cap[m];
      default: r = '0;
    endcase
    return r;
  endfunction

  initial begin : ref_model
    exp_t         e;
    logic [W-1:0] s2v, settled_change, ev, clr;
    logic         all_same;
    reset_model();
    forever begin
      @(posedge clk);
      e = '0;
      if (!reset_n) begin
        reset_model();
      end else begin
        for (int m = 0; m < 3; m++) e.rd[m] = read_reg(address, m);
        // input sampled two edges ago is what the filter sees now
        s2v = sync_q.pop_front();
        sync_q.push_back(in_port);
        void'(seen_q.pop_front());
        seen_q.push_back(s2v);
        // a bit is accepted when D consecutive samples agree on a new value
        settled_change = '0;
        for (int b = 0; b < W; b++) begin
          all_same = 1'b1;
          for (int i = 0; i < D; i++)
            if (seen_q[i][b] != s2v[b]) all_same = 1'b0;
          if (all_same && (s2v[b] != m_acc[b])) settled_change[b] = 1'b1;
        end
        clr = '0;
        if (chipselect && !write_n && address == 2'd3) clr = writedata[W-1:0];
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        for (int m = 0; m < 3; m++) begin
          ev = '0;
          for (int b = 0; b < W; b++)
            if (settled_change[b] && mode_hit(m, s2v[b])) ev[b] = 1'b1;
          m_cap[m] = (m_cap[m] & ~clr) | ev;
          e.irq[m] = |(m_cap[m] & m_mask);
        end
        m_acc = m_acc ^ settled_change;
      end
      exp_q.push_back(e);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: actual 0x%08h required 0x%08h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty @%0t: actual 0 entries required 1", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_rise", bus_r.readdata, e.rd[0]);
        chk("irq_rise", {31'b0, bus_r.irq}, {31'b0, e.irq[0]});
        chk("rd_fall", bus_f.readdata, e.rd[1]);
        chk("irq_fall", {31'b0, bus_f.irq}, {31'b0, e.irq[1]});
        chk("rd_any", bus_a.readdata, e.rd[2]);
        chk("irq_any", {31'b0, bus_a.irq}, {31'b0, e.irq[2]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset_n = 1'b0;
    repeat (n) @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  initial begin : stimulus
    // reset and read-back
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      @(negedge clk);
      chk("reset_read", bus_r.readdata, 32'h0);
    end
    chk("reset_irq", {31'b0, bus_r.irq}, 32'h0);
    wr(2'd2, 32'hFF);
    address = 2'd2;
    tick();
    @(negedge clk);
    chk("mask_readback", bus_r.readdata, 32'hFF);
    wr(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    tick();
    @(negedge clk);
    chk("reserved_read", bus_r.readdata, 32'h0);
    tick();

    // latency: bit 3 rises before edge k, capture and irq at edge k+5
    wr(2'd2, 32'h08);
    wr(2'd3, 32'hFF);
    address = 2'd3;
    in_port[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_irq_early", {31'b0, bus_r.irq}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_irq", {31'b0, bus_r.irq}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("lat_edgecap", bus_r.readdata, 32'h08);
    address = 2'd0;
    @(posedge clk);
    @(negedge clk);
    chk("lat_data", bus_r.readdata, 32'h08);
    tick();

    // glitch rejection
    in_port[3] = 1'b0;
    hold(8);
    wr(2'd3, 32'hFF);
    in_port[0] = 1'b1;
    hold(3);
    in_port[0] = 1'b0;
    hold(8);
    address = 2'd3;
    tick();
    @(negedge clk);
    chk("glitch_3cyc", bus_r.readdata, 32'h0);
    tick();
    in_port[0] = 1'b1;
    hold(4);
    in_port[0] = 1'b0;
    hold(8);
    @(negedge clk);
    chk("pulse_4cyc", bus_r.readdata, 32'h1);
    tick();

    // clear race: clear lands on the same edge as the set
    wr(2'd3, 32'hFF);
    in_port[0] = 1'b1;
    hold(5);
    wr(2'd3, 32'h01);
    tick();
    @(negedge clk);
    chk("clear_race", bus_r.readdata, 32'h1);
    tick();
    in_port[1] = 1'b1;
    hold(8);
    wr(2'd3, 32'h02);
    tick();
    @(negedge clk);
    chk("clear_bit1", bus_r.readdata, 32'h1);
    tick();

    // polarity modes on bit 2
    in_port = '0;
    hold(8);
    wr(2'd3, 32'hFF);
    in_port[2] = 1'b1;
    hold(8);
    in_port[2] = 1'b0;
    hold(8);
    in_port[2] = 1'b1;
    hold(8);
    wr(2'd3, 32'h04);
    in_port[2] = 1'b0;
    hold(8);
    address = 2'd3;
    tick();
    @(negedge clk);
    chk("mode_rise", bus_r.readdata, 32'h0);
    chk("mode_fall", bus_f.readdata, 32'h04);
    chk("mode_any", bus_a.readdata, 32'h04);
    tick();

    // reset mid-count with the input held high
    in_port = '0;
    hold(8);
    in_port[0] = 1'b1;
    hold(4);
    do_reset(2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midreset_early", bus_r.readdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("midreset_edge", bus_r.readdata, 32'h1);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      tick();
      if ($urandom_range(0, 499) == 0) begin
        chipselect = 1'b0;
        write_n    = 1'b1;
        do_reset($urandom_range(1, 3));
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    hold(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_in_edge.md
# gpio_in_edge

Parametrised Avalon-MM general-purpose input port for the fpgaSynth SOPC system, used for USB controller status lines and front-panel inputs. The block synchronises `WIDTH` asynchronous inputs, applies a per-bit debounce filter, and latches configurable edges into a sticky capture register. A maskable level interrupt is raised to the Nios II. Register 0 keeps the single-bit data-read behaviour of the existing input PIO; `WIDTH=1` with no write traffic is a drop-in replacement.

## Interface
- `WIDTH`, 8: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 1: number of consecutive stable cycles required before an input change is accepted, 1..65535. A value of 1 means no filtering.
- `EDGE_TYPE`, 0: edge to capture. 0 = rising, 1 = falling, 2 = any.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `write_n`  in  1  active-low write strobe. There is no wait state.
- `chipselect`  in  1  qualifies `write_n`.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous inputs.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA (read-only): debounced value, zero-extended.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (read/write): bits [WIDTH-1:0].
  - 3 EDGECAP (read, write-1-to-clear): bits [WIDTH-1:0].
- Writes take effect only when `chipselect=1` and `write_n=0`.
- Synchroniser: two flops per bit, `s1` then `s2`. Both reset to 0.
- Debounce, per bit (counter `cnt` of width clog2(DEBOUNCE_CYCLES)+1, register `stable`):
  - If `s2 == stable`, then `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Else, `cnt <= cnt+1`.
  - A pulse on `s2` shorter than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
- Edge event, per bit, in the same cycle `stable` updates:
  - rising: 0→1
  - falling: 1→0
  - any: either transition
- EDGECAP bit:
  - Set on an edge event.
  - Cleared by a write to address 3 with the matching `writedata` bit = 1.
  - A simultaneous set and clear leaves the bit set.
  - Writes to address 3 with a 0 bit leave that bit unchanged.
- `irq = |(EDGECAP & IRQMASK)`. This is driven from registers only, with no combinational path from bus inputs.
- `readdata` is re-registered every cycle from the address mux, regardless of read strobe. Bits [31:WIDTH] are always 0.
- Reset:
  - Returns `s1`, `s2`, `stable`, `cnt`, IRQMASK, EDGECAP, `readdata` and `irq` to 0.
  - An input held high through reset therefore produces one rising edge event after release.
  - Reset asserted mid-count abandons the count.

## Timing
- `in_port` bit changes before clock edge k and is held. Then:
  - `s1` captures at edge k.
  - `s2` captures at edge k+1.
  - `stable` and EDGECAP update at edge k+1+DEBOUNCE_CYCLES.
  - `irq` is valid in the same cycle as that EDGECAP update.
  - DATA or EDGECAP appear on `readdata` one edge later.
- Read latency: one cycle. `readdata` after edge n reflects `address` and register state sampled at edge n.
- IRQMASK write at edge n:
  - New mask visible on `irq` after edge n.
  - New mask visible on `readdata` (with address 2) after edge n+1.
- EDGECAP clear at edge n drops `irq` after edge n, unless an edge event occurs at edge n.
- Throughput: every bit can accept one edge per `DEBOUNCE_CYCLES` cycles. Events while EDGECAP is already set are merged, with no count.

## Test plan
- Reset and read-back: hold `in_port=0`, release reset. Then:
  - Read addresses 0–3; all return 0.
  - `irq=0`.
  - Write 0xFF to address 2; it reads back 0xFF.
  - Write 0xFFFFFFFF to address 1; it reads 0.
- Latency, with `WIDTH=8`, `DEBOUNCE_CYCLES=4`, rising edges:
  - Drive bit 3 high before edge k.
  - EDGECAP becomes 0x08 and `irq` asserts (mask 0x08) exactly at edge k+5, not earlier.
  - DATA reads 0x08.
- Glitch rejection, with `DEBOUNCE_CYCLES=4`:
  - A 3-cycle high pulse on bit 0 leaves DATA=0 and EDGECAP=0.
  - A 4-cycle pulse, aligned so `s2` holds it for 4 cycles, sets EDGECAP bit 0.
- Clear race:
  - Write 0x01 to address 3 on the same edge that a bit 0 edge event occurs: EDGECAP bit 0 stays 1.
  - Write 0x02 with bit 1 set: only bit 1 clears.
- Mode checks:
  - With `EDGE_TYPE=1`, a 0→1→0 sequence on bit 2 sets only on the falling edge.
  - With `EDGE_TYPE=2`, the same sequence sets once; clear it between transitions and it sets again.
  - Masked bits never assert `irq`.
- Reset mid-count:
  - Assert `reset_n` low while `cnt=2`, with `in_port` high.
  - After release, a rising edge event occurs at release edge + 1 + DEBOUNCE_CYCLES, and no earlier.
